// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Purpose  : Raster timing bundle between the timing generator and its users.
// Revision : 1.0
// ============================================================================
interface vga_timing_gen_if #(
  parameter int HW = 11,
  parameter int VW = 10
);
  logic          enable;
  logic          hsync;
  logic          vsync;
  logic          hblank;
  logic          vblank;
  logic          de;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          fetch_valid;
  logic [HW-1:0] fetch_x;
  logic [VW-1:0] fetch_y;

  // Generator side: produces timing, consumes the advance enable.
  modport master (
    input  enable,
    output hsync, vsync, hblank, vblank, de, x, y,
    output line_start, frame_start,
    output fetch_valid, fetch_x, fetch_y
  );

  // Consumer side: pixel pipeline, line buffers and pin drivers.
  modport slave (
    output enable,
    input  hsync, vsync, hblank, vblank, de, x, y,
    input  line_start, frame_start,
    input  fetch_valid, fetch_x, fetch_y
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Programmable H/V raster timing with a pixel-fetch lookahead port.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int LOOKAHEAD = 2,
  parameter int HW        = 11,
  parameter int VW        = 10
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Region bounds carry one extra bit so an end bound equal to 2^W cannot wrap.
  localparam logic [HW:0] H_ACT_END = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG    = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_END = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG    = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          hblank;
    logic          vblank;
    logic          de;
    logic          line_start;
    logic          frame_start;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
  } disp_t;

  localparam disp_t IDLE = '{
    hsync:       ~H_POL,
    vsync:       ~V_POL,
    hblank:      1'b1,
    vblank:      1'b1,
    de:          1'b0,
    line_start:  1'b0,
    frame_start: 1'b0,
    x:           '0,
    y:           '0
  };

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  disp_t         dec;
  logic          hs_act;
  logic          vs_act;

  // Stage 0 is the fetch stage; stage LOOKAHEAD drives the display outputs.
  disp_t pipe_q [LOOKAHEAD+1];
  disp_t pipe_d [LOOKAHEAD+1];

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vga.enable) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    hs_act          = ({1'b0, h_cnt_q} >= HS_BEG) && ({1'b0, h_cnt_q} < HS_END);
    vs_act          = ({1'b0, v_cnt_q} >= VS_BEG) && ({1'b0, v_cnt_q} < VS_END);
    dec             = IDLE;
    dec.hsync       = H_POL ? hs_act : ~hs_act;
    dec.vsync       = V_POL ? vs_act : ~vs_act;
    dec.hblank      = ({1'b0, h_cnt_q} >= H_ACT_END);
    dec.vblank      = ({1'b0, v_cnt_q} >= V_ACT_END);
    dec.de          = ~dec.hblank & ~dec.vblank;
    dec.line_start  = (h_cnt_q == '0);
    dec.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    dec.x           = h_cnt_q;
    dec.y           = v_cnt_q;
  end

  always_comb begin
    pipe_d = pipe_q;
    if (vga.enable) begin
      pipe_d[0] = dec;
      for (int i = 1; i <= LOOKAHEAD; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      for (int i = 0; i <= LOOKAHEAD; i++) begin
        pipe_q[i] <= IDLE;
      end
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      for (int i = 0; i <= LOOKAHEAD; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign vga.fetch_valid = pipe_q[0].de;
  assign vga.fetch_x     = pipe_q[0].x;
  assign vga.fetch_y     = pipe_q[0].y;

  assign vga.hsync       = pipe_q[LOOKAHEAD].hsync;
  assign vga.vsync       = pipe_q[LOOKAHEAD].vsync;
  assign vga.hblank      = pipe_q[LOOKAHEAD].hblank;
  assign vga.vblank      = pipe_q[LOOKAHEAD].vblank;
  assign vga.de          = pipe_q[LOOKAHEAD].de;
  assign vga.x           = pipe_q[LOOKAHEAD].x;
  assign vga.y           = pipe_q[LOOKAHEAD].y;
  assign vga.line_start  = pipe_q[LOOKAHEAD].line_start;
  assign vga.frame_start = pipe_q[LOOKAHEAD].frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench: default 800x600 line timing and
//            stall, plus a tiny 8x4 raster at LOOKAHEAD 0 and 8.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_s_n = 1'b0;
  int   ec = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.HW(11), .VW(10)) if_a ();
  vga_timing_gen_if #(.HW(4),  .VW(3))  if_b ();
  vga_timing_gen_if #(.HW(4),  .VW(3))  if_c ();

  vga_timing_gen #(.LOOKAHEAD(2)) u_a (
    .clk_pixel(clk), .reset_n(rst_a_n), .vga(if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .LOOKAHEAD(0), .HW(4), .VW(3)
  ) u_b (
    .clk_pixel(clk), .reset_n(rst_s_n), .vga(if_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .LOOKAHEAD(8), .HW(4), .VW(3)
  ) u_c (
    .clk_pixel(clk), .reset_n(rst_s_n), .vga(if_c)
  );

  // {hsync, vsync, hblank, vblank, de, line_start, frame_start, x, y}
  logic [27:0] disp_a;
  logic [13:0] disp_b, disp_c;
  logic [21:0] fetch_a;
  logic [7:0]  fetch_b, fetch_c;

  assign disp_a  = {if_a.hsync, if_a.vsync, if_a.hblank, if_a.vblank, if_a.de,
                    if_a.line_start, if_a.frame_start, if_a.x, if_a.y};
  assign disp_b  = {if_b.hsync, if_b.vsync, if_b.hblank, if_b.vblank, if_b.de,
                    if_b.line_start, if_b.frame_start, if_b.x, if_b.y};
  assign disp_c  = {if_c.hsync, if_c.vsync, if_c.hblank, if_c.vblank, if_c.de,
                    if_c.line_start, if_c.frame_start, if_c.x, if_c.y};
  assign fetch_a = {if_a.fetch_valid, if_a.fetch_x, if_a.fetch_y};
  assign fetch_b = {if_b.fetch_valid, if_b.fetch_x, if_b.fetch_y};
  assign fetch_c = {if_c.fetch_valid, if_c.fetch_x, if_c.fetch_y};

  // Small raster: H_TOTAL 12, hsync low on h 9..10; V_TOTAL 7, vsync low on v 5.
  // p is the raster position counted from (0,0); p < 0 means idle.
  function automatic logic [13:0] s_disp(input int p);
    int   h, v;
    logic hb, vb;
    if (p < 0) return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
    h  = p % 12;
    v  = (p / 12) % 7;
    hb = (h >= 8);
    vb = (v >= 4);
    return {~(h == 9 || h == 10), ~(v == 5), hb, vb, ~hb & ~vb,
            h == 0, (h == 0) && (v == 0), 4'(h), 3'(v)};
  endfunction

  function automatic logic [7:0] s_fetch(input int p);
    int h, v;
    if (p < 0) return 8'd0;
    h = p % 12;
    v = (p / 12) % 7;
    return {(h < 8) && (v < 4), 4'(h), 3'(v)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ec++;
    @(negedge clk);
  endtask

  int  de_cnt, de_end, hs_rise, hs_cnt, hs_low, fs_second, ls_edge;
  bit  found;

  initial begin
    if_a.enable = 1'b1;
    if_b.enable = 1'b1;
    if_c.enable = 1'b1;

    // ---------------- small raster, LOOKAHEAD 0 and 8 ----------------
    repeat (10) tick();
    check("b_idle_disp",  disp_b,  s_disp(-1));
    check("b_idle_fetch", fetch_b, 8'd0);
    check("c_idle_disp",  disp_c,  s_disp(-1));
    check("c_idle_fetch", fetch_c, 8'd0);

    rst_s_n = 1'b1;
    ec = 0;
    for (int k = 0; k < 178; k++) begin
      tick();
      check("b_disp",  disp_b,  s_disp(ec - 1));
      check("b_fetch", fetch_b, s_fetch(ec - 1));
      check("c_disp",  disp_c,  s_disp(ec - 9));
      check("c_fetch", fetch_c, s_fetch(ec - 1));
    end

    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (if_b.y == 3'd3) found = 1'b1;
      else tick();
    end
    check("b_wait_y3", found, 1'b1);

    rst_s_n = 1'b0;
    tick();
    check("b_midreset_disp",  disp_b,  s_disp(-1));
    check("b_midreset_fetch", fetch_b, 8'd0);
    check("c_midreset_disp",  disp_c,  s_disp(-1));
    check("c_midreset_fetch", fetch_c, 8'd0);
    tick();

    rst_s_n = 1'b1;
    ec = 0;
    hs_low = 0;
    fs_second = -1;
    for (int k = 0; k < 178; k++) begin
      tick();
      check("b2_disp",  disp_b,  s_disp(ec - 1));
      check("c2_disp",  disp_c,  s_disp(ec - 9));
      check("c2_fetch", fetch_c, s_fetch(ec - 1));
      if (ec <= 12 && !if_b.hsync) hs_low++;
      if (ec > 1 && if_b.frame_start && fs_second < 0) fs_second = ec;
    end
    check("b_hsync_low_width", hs_low, 2);
    check("b_frame_period", fs_second, 85);

    // ---------------- default timing, LOOKAHEAD 2 ----------------
    check("a_idle_hsync",  if_a.hsync,       1'b0);
    check("a_idle_vsync",  if_a.vsync,       1'b0);
    check("a_idle_hblank", if_a.hblank,      1'b1);
    check("a_idle_vblank", if_a.vblank,      1'b1);
    check("a_idle_de",     if_a.de,          1'b0);
    check("a_idle_x",      if_a.x,           11'd0);
    check("a_idle_y",      if_a.y,           10'd0);
    check("a_idle_ls",     if_a.line_start,  1'b0);
    check("a_idle_fs",     if_a.frame_start, 1'b0);
    check("a_idle_fetch",  fetch_a,          22'd0);

    rst_a_n = 1'b1;
    ec = 0;
    tick();
    check("a_e1_fetch", fetch_a, {1'b1, 11'd0, 10'd0});
    check("a_e1_de",    if_a.de, 1'b0);
    tick();
    check("a_e2_disp",  disp_a, {7'b0011000, 11'd0, 10'd0});
    tick();
    check("a_e3_first", {if_a.de, if_a.x, if_a.y, if_a.frame_start, if_a.line_start},
          {1'b1, 11'd0, 10'd0, 1'b1, 1'b1});

    de_cnt = 0; de_end = -1; hs_rise = -1; hs_cnt = 0;
    for (int k = 0; k < 1056; k++) begin
      if (if_a.de) de_cnt++;
      else if (de_end < 0) de_end = ec;
      if (if_a.hsync) begin
        hs_cnt++;
        if (hs_rise < 0) hs_rise = ec;
      end
      if (k == 840) check("a_fetch_lead", {if_a.x, if_a.fetch_x}, {11'd840, 11'd842});
      tick();
    end
    check("a_de_count",   de_cnt,  800);
    check("a_de_end",     de_end,  803);
    check("a_hs_rise",    hs_rise, 843);
    check("a_hs_width",   hs_cnt,  128);
    check("a_line2_start", {if_a.line_start, if_a.frame_start, if_a.x, if_a.y},
          {1'b1, 1'b0, 11'd0, 10'd1});

    repeat (400) tick();
    check("a_pre_stall_x", if_a.x, 11'd400);
    if_a.enable = 1'b0;
    for (int k = 0; k < 37; k++) begin
      tick();
      check("a_stall_disp",  disp_a,  {7'b0000100, 11'd400, 10'd1});
      check("a_stall_fetch", fetch_a, {1'b1, 11'd402, 10'd1});
    end
    if_a.enable = 1'b1;
    tick();
    check("a_resume", {if_a.x, if_a.fetch_x}, {11'd401, 11'd403});

    ls_edge = -1;
    for (int k = 0; k < 2000 && ls_edge < 0; k++) begin
      tick();
      if (if_a.line_start) ls_edge = ec;
    end
    check("a_stalled_line_period", ls_edge, 2152);

    if_a.enable = 1'b0;
    rst_a_n = 1'b0;
    tick();
    check("a_reset_over_enable_disp",  disp_a,  {7'b0011000, 11'd0, 10'd0});
    check("a_reset_over_enable_fetch", fetch_a, 22'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
